mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MAX_WAIT, default 255, SHALL set the number of memory wait cycles before a transaction is aborted; legal range 1..65535.
REQ-002 Parameter RESET_DATA_FIRST, default 1, SHALL set the initial round-robin pointer: 1 = data port wins the first tie, 0 = fetch port wins.
REQ-003 Port list, in order: name, direction, width, meaning.
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- if_req  input  1  fetch port request.
- if_addr  input  32  fetch address.
- if_rdata  output  32  fetch read data.
- if_done  output  1  fetch complete, one-cycle pulse.
- d_req  input  1  data port request.
- d_we  input  1  data write enable.
- d_wstrb  input  4  byte strobes.
- d_addr  input  32  data address.
- d_wdata  input  32  write data.
- d_rdata  output  32  data read data.
- d_done  output  1  data complete, one-cycle pulse.
- mem_req  output  1  memory request.
- mem_we  output  1  memory write.
- mem_wstrb  output  4  memory strobes.
- mem_addr  output  32  memory address.
- mem_wdata  output  32  memory write data.
- mem_ready  input  1  memory accept/complete.
- mem_rdata  input  32  memory read data.
- err  output  1  timeout flag; pulses together with the aborted port's done.

Function
REQ-004 The FSM SHALL have exactly the states IDLE, IF_BUSY and D_BUSY.
REQ-005 In IDLE with exactly one request high, the FSM SHALL grant that port at the next edge.
REQ-006 In IDLE with both requests high, the FSM SHALL grant the port not granted last; the pointer updates only on grant.
REQ-007 On grant, the FSM SHALL register the port's address, we, wstrb and wdata onto mem_* and assert mem_req from the following cycle.
REQ-008 Fetch grants SHALL drive mem_we=0, mem_wstrb=0 and mem_wdata=0.
REQ-009 mem_req and all mem_* outputs SHALL remain stable until the edge where mem_req && mem_ready is true.
REQ-010 At the completing edge, the FSM SHALL drop mem_req, pulse the granted port's done for one cycle, load its rdata from mem_rdata (reads) or 0 (writes), and return to IDLE.
REQ-011 rdata outputs SHALL hold their value until the next completion on the same port.
REQ-012 Minimum latency SHALL be 2 edges: request sampled at edge N, done high after edge N+1 when mem_ready is high in the first mem_req cycle.
REQ-013 The IDLE cycle coinciding with a done pulse SHALL arbitrate normally, so a held request starts a back-to-back transaction.
REQ-014 Requesters SHALL hold req and payload stable until done; the arbiter samples payload only at grant.
REQ-015 Requests arriving during BUSY SHALL be ignored until IDLE; no request is lost while req is held.
REQ-016 A 16-bit wait counter SHALL clear at grant and increment each mem_req cycle with mem_ready low.
REQ-017 When the wait counter equals MAX_WAIT with mem_ready low, the FSM SHALL drop mem_req, pulse done and err together, load rdata=0, and return to IDLE.
REQ-018 When mem_ready is high in the same cycle the counter reaches MAX_WAIT, the transaction SHALL complete normally with err=0.
REQ-019 mem_ready while mem_req is low SHALL be ignored.

Reset
REQ-020 While reset is low, the block SHALL force IDLE, all outputs to 0, the wait counter to 0 and the pointer per RESET_DATA_FIRST, asynchronously.
REQ-021 A reset asserted mid-transaction SHALL abort the transaction with no done pulse; the first grant occurs no earlier than the second rising edge after reset deasserts.

Verification
REQ-022 Single fetch: if_req=1, if_addr=0x100, mem_ready high in the first cycle, mem_rdata=0x00000013 -> mem_addr=0x100, if_done pulse after 2 edges, if_rdata=0x13.
REQ-023 Tie: both requests held with RESET_DATA_FIRST=1 and four transactions -> grant order D, IF, D, IF.
REQ-024 Write: d_we=1, d_wstrb=4'b0011, d_addr=0x2000, d_wdata=0xDEADBEEF, mem_ready after 3 wait cycles -> mem_* stable for 4 cycles, d_done pulse, d_rdata=0.
REQ-025 Timeout: MAX_WAIT=4, mem_ready stuck low -> mem_req high 5 cycles, then d_done=1 and err=1 for one cycle, FSM back in IDLE.
REQ-026 Reset mid-transaction: reset low during D_BUSY -> mem_req=0 immediately, no d_done; after release, a pending if_req is granted normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) round-robin arbiter onto a single memory port.
// One outstanding transaction; aborts with err after MAX_WAIT unanswered cycles.
module mem_arbiter #(
    parameter int unsigned MAX_WAIT         = 255,
    parameter bit          RESET_DATA_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_wstrb,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        err
);

    typedef enum logic [1:0] {StIdle, StIfBusy, StDBusy} state_e;

    localparam logic [15:0] MaxWait = 16'(MAX_WAIT);

    state_e      state_q, state_d;
    logic        prio_data_q, prio_data_d;
    logic        armed_q;
    logic [15:0] wait_q, wait_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        if_done_q, if_done_d;
    logic        d_done_q, d_done_d;
    logic        err_q, err_d;
    logic        grant_data;
    logic [31:0] rd_val;

    // prio_data_q set means the data port wins the next tie
    assign grant_data = d_req && (!if_req || prio_data_q);

    always_comb begin
        state_d     = state_q;
        prio_data_d = prio_data_q;
        wait_d      = wait_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_wstrb_d = mem_wstrb_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_done_d   = 1'b0;
        d_done_d    = 1'b0;
        err_d       = 1'b0;
        rd_val      = (mem_ready && !mem_we_q) ? mem_rdata : 32'h0;

        case (state_q)
            StIdle: begin
                if (armed_q && (if_req || d_req)) begin
                    wait_d    = 16'h0;
                    mem_req_d = 1'b1;
                    if (grant_data) begin
                        state_d     = StDBusy;
                        prio_data_d = 1'b0;
                        mem_we_d    = d_we;
                        mem_wstrb_d = d_wstrb;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                    end else begin
                        state_d     = StIfBusy;
                        prio_data_d = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_wstrb_d = 4'h0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = 32'h0;
                    end
                end
            end
            StIfBusy, StDBusy: begin
                // mem_req is always high here, so mem_ready is meaningful
                if (mem_ready || (wait_q == MaxWait)) begin
                    state_d   = StIdle;
                    mem_req_d = 1'b0;
                    err_d     = !mem_ready;
                    if (state_q == StDBusy) begin
                        d_done_d  = 1'b1;
                        d_rdata_d = rd_val;
                    end else begin
                        if_done_d  = 1'b1;
                        if_rdata_d = rd_val;
                    end
                end else begin
                    wait_d = wait_q + 16'h1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            prio_data_q <= RESET_DATA_FIRST;
            armed_q     <= 1'b0;
            wait_q      <= 16'h0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wstrb_q <= 4'h0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            if_rdata_q  <= 32'h0;
            d_rdata_q   <= 32'h0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_data_q <= prio_data_d;
            armed_q     <= 1'b1;
            wait_q      <= wait_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_wstrb_q <= mem_wstrb_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_done_q   <= if_done_d;
            d_done_q    <= d_done_d;
            err_q       <= err_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_wstrb = mem_wstrb_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_done   = if_done_q;
    assign d_done    = d_done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table of single transactions, scoreboard of
// completions, plus tie, timeout and mid-transaction reset sequences.
module tb_mem_arbiter;

    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [3:0]  d_wstrb = '0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        err;

    mem_arbiter #(.MAX_WAIT(MW), .RESET_DATA_FIRST(1'b1)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .d_req(d_req), .d_we(d_we), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_data;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrdata;
        int          wait_cyc;   // ready-low cycles before ready; >MW means never
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic        is_data;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] m_if_rdata = '0;
    logic [31:0] m_d_rdata = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (reset && (if_done || d_done)) begin
            if (sb.size() == 0) begin
                chk("spurious_done", {62'h0, d_done, if_done}, 64'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_port", {62'h0, d_done, if_done}, e.is_data ? 64'h2 : 64'h1);
                chk("done_err", {63'h0, err}, {63'h0, e.err});
                if (e.is_data) m_d_rdata = e.rdata;
                else m_if_rdata = e.rdata;
                chk("d_rdata", {32'h0, d_rdata}, {32'h0, m_d_rdata});
                chk("if_rdata", {32'h0, if_rdata}, {32'h0, m_if_rdata});
            end
        end
    end

    // Caller is positioned at a negedge; returns at a negedge one idle cycle after done
    task automatic do_txn(input vec_t v);
        logic [36:0] exp_bus;
        bit          fin;
        int          k;
        sb.push_back('{v.is_data, v.exp_rdata, v.exp_err});
        exp_bus = v.is_data ? {v.we, v.wstrb, v.wdata} : 37'h0;
        if (v.is_data) begin
            d_req = 1'b1; d_we = v.we; d_wstrb = v.wstrb; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
            d_we = 1'b1; d_wstrb = 4'hF; d_wdata = 32'hFFFF_FFFF;
        end
        mem_ready = 1'b0;
        @(posedge clk);
        fin = 1'b0;
        k = 0;
        while (!fin) begin
            @(negedge clk);
            chk("busy_mem_req", {63'h0, mem_req}, 64'h1);
            chk("busy_mem_addr", {32'h0, mem_addr}, {32'h0, v.addr});
            chk("busy_mem_bus", {27'h0, mem_we, mem_wstrb, mem_wdata}, {27'h0, exp_bus});
            chk("busy_no_done", {62'h0, if_done, d_done}, 64'h0);
            mem_rdata = v.mrdata;
            mem_ready = (k == v.wait_cyc);
            if (k == v.wait_cyc || k == MW) fin = 1'b1;
            k++;
        end
        @(negedge clk);
        chk("done_pulse", {63'h0, v.is_data ? d_done : if_done}, 64'h1);
        chk("done_mem_req", {63'h0, mem_req}, 64'h0);
        if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        chk("after_idle", {61'h0, mem_req, if_done | d_done, err}, 64'h0);
    endtask

    vec_t vecs[7];

    initial begin
        int cnt;
        vecs[0] = '{1'b0, 1'b0, 4'h0, 32'h100,  32'h0,         32'h13,        0,  1'b0, 32'h13};
        vecs[1] = '{1'b1, 1'b1, 4'h3, 32'h2000, 32'hDEADBEEF,  32'hFFFF_FFFF, 3,  1'b0, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 4'h0, 32'h3004, 32'h0,         32'hCAFEF00D,  1,  1'b0, 32'hCAFEF00D};
        vecs[3] = '{1'b0, 1'b0, 4'h0, 32'h104,  32'h0,         32'h12345678,  MW, 1'b0, 32'h12345678};
        vecs[4] = '{1'b1, 1'b0, 4'h0, 32'h4000, 32'h0,         32'hAAAA5555,  99, 1'b1, 32'h0};
        vecs[5] = '{1'b0, 1'b0, 4'h0, 32'h108,  32'h0,         32'h87654321,  99, 1'b1, 32'h0};
        vecs[6] = '{1'b1, 1'b0, 4'hF, 32'h5000, 32'h11111111,  32'h0BADF00D,  2,  1'b0, 32'h0BADF00D};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_mem_req", {63'h0, mem_req}, 64'h0);
        chk("rst_mem_bus", {27'h0, mem_we, mem_wstrb, mem_wdata}, 64'h0);
        chk("rst_mem_addr", {32'h0, mem_addr}, 64'h0);
        chk("rst_done_err", {61'h0, if_done, d_done, err}, 64'h0);
        chk("rst_rdata", {if_rdata, d_rdata}, 64'h0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Tie from reset: D, IF, D, IF with both requests held
        d_req = 1'b1; d_we = 1'b0; d_wstrb = 4'h0; d_addr = 32'h6000; d_wdata = 32'h0;
        if_req = 1'b1; if_addr = 32'h7000;
        mem_ready = 1'b1;
        sb.push_back('{1'b1, ~32'h6000, 1'b0});
        sb.push_back('{1'b0, ~32'h7000, 1'b0});
        sb.push_back('{1'b1, ~32'h6000, 1'b0});
        sb.push_back('{1'b0, ~32'h7000, 1'b0});
        cnt = 0;
        for (int c = 0; c < 40 && cnt < 4; c++) begin
            @(negedge clk);
            if (if_done || d_done) cnt++;
            if (cnt == 4) begin
                if_req = 1'b0; d_req = 1'b0;
            end
            mem_rdata = ~mem_addr;
        end
        mem_ready = 1'b0;
        @(negedge clk);
        chk("tie_count", 64'(cnt), 64'd4);
        chk("tie_sb_empty", 64'(sb.size()), 64'd0);

        // Table-driven single transactions
        for (int i = 0; i < 7; i++) do_txn(vecs[i]);
        chk("table_sb_empty", 64'(sb.size()), 64'd0);

        // Reset during D_BUSY, fetch pending across the reset
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8000;
        mem_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_busy_req", {63'h0, mem_req}, 64'h1);
        if_req = 1'b1; if_addr = 32'h9000;
        #2 reset = 1'b0;
        #1;
        chk("rst_async_req", {63'h0, mem_req}, 64'h0);
        chk("rst_async_done", {61'h0, if_done, d_done, err}, 64'h0);
        chk("rst_async_rdata", {if_rdata, d_rdata}, 64'h0);
        m_if_rdata = '0; m_d_rdata = '0;
        d_req = 1'b0;
        repeat (2) @(negedge clk);
        mem_rdata = 32'h600DD00D;
        mem_ready = 1'b1;
        sb.push_back('{1'b0, 32'h600DD00D, 1'b0});
        reset = 1'b1;
        @(negedge clk);
        chk("rst_first_edge", {63'h0, mem_req}, 64'h0);
        @(negedge clk);
        chk("rst_second_edge", {63'h0, mem_req}, 64'h1);
        chk("rst_grant_addr", {32'h0, mem_addr}, 64'h9000);
        @(negedge clk);
        chk("rst_if_done", {62'h0, if_done, d_done}, 64'h2);
        if_req = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        chk("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
